// File: rtl/mdio_pkg.sv
// Shared types and constants for the MDIO access arbiter and its requesters.
// Field widths follow the clause-22 MDIO frame: 5-bit PHY/register address, 16-bit data.
package mdio_pkg;

  localparam int PHY_W  = 5;
  localparam int REG_W  = 5;
  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] ERR_RDATA       = 16'hFFFF;
  localparam logic [REG_W-1:0]  PAGE_REG        = 5'd22;
  localparam logic [REG_W-1:0]  COPPER_CTRL_REG = 5'd24;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_RESP     = 3'd3,
    ST_LOCKED   = 3'd4
  } state_e;

  typedef struct packed {
    logic              write;
    logic [PHY_W-1:0]  phy;
    logic [REG_W-1:0]  reg_addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Round-robin successor of a requester index.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mdio_rr_arb.sv
// Round-robin pick: first set request at or after ptr, wrapping. Purely combinational.
// No state and no backpressure; the caller decides when the grant is consumed.
module mdio_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IDXW = $clog2(NREQ);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[(int'(ptr) + i) % NREQ]) begin
        any = 1'b1;
        idx = IDXW'((int'(ptr) + i) % NREQ);
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mdio_access_arbiter.sv
// Shares one MDIO master among NREQ requesters: accept -> command next cycle, response one cycle after m_rsp_valid.
// Requesters hold req_valid until req_ready; the command is held until m_cmd_ready; a dead PHY times out after TIMEOUT cycles.
module mdio_access_arbiter
  import mdio_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rstf,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_write,
  input  logic [NREQ-1:0]         req_lock,
  input  logic [NREQ*PHY_W-1:0]   req_phy,
  input  logic [NREQ*REG_W-1:0]   req_reg,
  input  logic [NREQ*DATA_W-1:0]  req_wdata,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  output logic                    m_cmd_write,
  output logic [PHY_W-1:0]        m_cmd_phy,
  output logic [REG_W-1:0]        m_cmd_reg,
  output logic [DATA_W-1:0]       m_cmd_wdata,
  input  logic                    m_rsp_valid,
  input  logic [DATA_W-1:0]       m_rsp_rdata
);

  localparam int IDXW  = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e             state_q;
  logic [IDXW-1:0]    ptr_q, owner_q, sel_idx, arb_idx;
  logic [NREQ-1:0]    arb_grant;
  logic               arb_any, acc_vld, lock_q, err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  rdata_q;
  cmd_t               cmd_q, sel_cmd;

  mdio_rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // While locked only the owner may be accepted; acceptance is masked during reset.
  always_comb begin
    acc_vld   = 1'b0;
    sel_idx   = arb_idx;
    req_ready = '0;
    if (rstf) begin
      if (state_q == ST_IDLE) begin
        acc_vld   = arb_any;
        req_ready = arb_grant;
      end else if (state_q == ST_LOCKED) begin
        sel_idx            = owner_q;
        acc_vld            = req_valid[owner_q];
        req_ready[owner_q] = req_valid[owner_q];
      end
    end
    sel_cmd.write    = req_write[sel_idx];
    sel_cmd.phy      = req_phy[int'(sel_idx)*PHY_W +: PHY_W];
    sel_cmd.reg_addr = req_reg[int'(sel_idx)*REG_W +: REG_W];
    sel_cmd.wdata    = req_wdata[int'(sel_idx)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cmd_q   <= '0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_LOCKED: begin
          if (acc_vld) begin
            owner_q <= sel_idx;
            cmd_q   <= sel_cmd;
            lock_q  <= req_lock[sel_idx];
            state_q <= ST_ISSUE;
          end else if (state_q == ST_LOCKED) begin
            // Owner went quiet: release the lock so others are not starved.
            if (cnt_q == CNT_MAX) begin
              ptr_q   <= IDXW'(next_idx(int'(owner_q), NREQ));
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (m_cmd_ready) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (m_rsp_valid) begin
            rdata_q <= m_rsp_rdata;
            err_q   <= 1'b0;
            state_q <= ST_RESP;
          end else if (cnt_q == CNT_MAX) begin
            rdata_q <= ERR_RDATA;
            err_q   <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (lock_q) begin
            cnt_q   <= '0;
            state_q <= ST_LOCKED;
          end else begin
            ptr_q   <= IDXW'(next_idx(int'(owner_q), NREQ));
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    m_cmd_valid = 1'b0;
    m_cmd_write = 1'b0;
    m_cmd_phy   = '0;
    m_cmd_reg   = '0;
    m_cmd_wdata = '0;
    rsp_valid   = '0;
    rsp_rdata   = '0;
    rsp_err     = 1'b0;
    if (state_q == ST_ISSUE) begin
      m_cmd_valid = 1'b1;
      m_cmd_write = cmd_q.write;
      m_cmd_phy   = cmd_q.phy;
      m_cmd_reg   = cmd_q.reg_addr;
      m_cmd_wdata = cmd_q.wdata;
    end
    if (state_q == ST_RESP) begin
      rsp_valid[owner_q] = 1'b1;
      rsp_rdata          = rdata_q;
      rsp_err            = err_q;
    end
  end

endmodule

// File: doc/mdio_access_arbiter.md
# mdio_access_arbiter

Shares one MDIO management master among NREQ independent requesters, such as link-config FSMs, PHY polling and software CSR bridges. It arbitrates round-robin, forwards one register command at a time to the master's command port, waits for completion, and routes the response back to the owner. It supports a lock so that a paged access (page-select write followed by a register read or write) completes atomically. It also bounds every transaction with a timeout so that a dead PHY cannot hang the bus.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 1023: maximum cycles spent waiting in WAIT_RSP before an error response.
- clk  in  1  clock; all state updates on rising edge.
- rstf  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester command valid; held until accepted.
- req_ready  out  NREQ  one-hot acceptance pulse, 1 cycle.
- req_write  in  NREQ  1 = write, 0 = read.
- req_lock  in  NREQ  hold the grant after this command completes.
- req_phy  in  NREQ*5  PHY address; requester i uses bits [5i+4:5i].
- req_reg  in  NREQ*5  register address, same packing.
- req_wdata  in  NREQ*16  write data, same packing.
- rsp_valid  out  NREQ  one-hot response pulse, 1 cycle.
- rsp_rdata  out  16  read data, shared; valid only with rsp_valid.
- rsp_err  out  1  timeout flag, shared; valid only with rsp_valid.
- m_cmd_valid  out  1  command to MDIO master.
- m_cmd_ready  in  1  master accepts the command.
- m_cmd_write, m_cmd_phy[4:0], m_cmd_reg[4:0], m_cmd_wdata[15:0]  out  command fields.
- m_rsp_valid  in  1  master done; 1-cycle pulse.
- m_rsp_rdata  in  16  read data from the master.

## Operation
- States: IDLE, ISSUE, WAIT_RSP, RESP, LOCKED.
- IDLE:
  - If any req_valid is set, select the winner as the first set bit at or after ptr, wrapping modulo NREQ.
  - Assert req_ready[winner] combinationally.
  - Register owner, cmd fields and the lock bit.
  - Go to ISSUE.
- ISSUE:
  - m_cmd_valid=1 with the registered fields, which stay stable until accepted.
  - On m_cmd_ready, clear the timeout counter and go to WAIT_RSP.
- WAIT_RSP:
  - On m_rsp_valid, capture m_rsp_rdata, set err=0, go to RESP.
  - Otherwise increment the counter. When the counter equals TIMEOUT, set rdata=16'hFFFF, err=1, go to RESP.
- RESP:
  - rsp_valid[owner]=1 for one cycle.
  - If lock=1, go to LOCKED. Otherwise set ptr=(owner+1) mod NREQ and go to IDLE.
- LOCKED:
  - Only req_valid[owner] is considered; it is accepted exactly as in IDLE and the lock bit is re-registered.
  - Other requesters wait.
  - An idle counter releases the lock after TIMEOUT cycles without an owner request: ptr=owner+1, go to IDLE, no response generated.
- An m_rsp_valid arriving outside WAIT_RSP is ignored.
- Default outputs outside the states above are all zero.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, m_cmd_valid=0, m_cmd fields=0, counters=0.
- Request accepted in cycle 0 → m_cmd_valid from cycle 1.
- m_cmd_ready in cycle a → WAIT_RSP from a+1.
- m_rsp_valid in cycle k → rsp_valid in k+1 → next acceptance no earlier than k+2.
- Timeout: m_cmd_ready in cycle a with no response → rsp_valid with err=1 in cycle a+TIMEOUT+2.
- m_rsp_valid in the same cycle the counter hits TIMEOUT: the response wins and err=0.
- Counter width is $clog2(TIMEOUT+1) and it saturates; the counter never wraps.
- Reset mid-transaction returns everything to reset values within the same cycle (asynchronous). No response is issued for the aborted command. The MDIO master must be reset together with this block.
- Requester deasserting req_valid before acceptance: legal, no effect.

## Structure
- mdio_pkg holds:
  - the state enum;
  - PHY_W=5, REG_W=5, DATA_W=16;
  - ERR_RDATA=16'hFFFF;
  - named register constants PAGE_REG=5'd22 and COPPER_CTRL_REG=5'd24, used by the bench and by requesters.
- Sub-module mdio_rr_arb handles the combinational round-robin pick. Inputs: request vector and ptr. Outputs: one-hot grant, binary index, any flag.

## Test plan
- Read: req0 reads phy 0, reg 0x18; master returns 16'h2000 → rsp_valid[0]=1, rsp_rdata=16'h2000, rsp_err=0 one cycle after m_rsp_valid.
- Fairness: req0 and req2 held valid continuously from reset → grant order 0,2,0,2; req_ready is never two-hot.
- Lock: req2 writes reg 22 = 16'h0002 with lock=1 while req0 is valid, then req2 reads reg 0x18 with lock=0 → both req2 commands complete before req0 is accepted.
- Timeout: TIMEOUT=15, master never responds → rsp_err=1, rsp_rdata=16'hFFFF in cycle a+17.
- Backpressure: m_cmd_ready held low for 5 cycles → m_cmd_valid and m_cmd fields stay constant. Exactly one command is transferred.
- Reset mid-op: rstf asserted during WAIT_RSP, then released; a late m_rsp_valid arrives → no rsp_valid. A new req1 write completes normally.
